// File: rtl/display_sequencer.sv
// Display-mux selector: steps through SET/AVE/MIN/MAX on debounced button presses
// (MANUAL) or on a dwell timer (AUTO), skipping MIN/MAX while statistics are invalid.
module display_sequencer #(
    parameter int TICK_DIV    = 100000,
    parameter int DWELL_MS    = 2000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       auto_en,
    input  logic       stats_valid,
    output logic [1:0] sel,
    output logic       sel_change,
    output logic       auto_mode
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DWL_W = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
    localparam int DEB_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DWELL_MS - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_MS - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               btn_sync_p0;
    logic               btn_sync_p1;
    logic               auto_sync_p0;
    logic               auto_sync_p1;
    logic [PRE_W-1:0]   prescale;
    logic               tick;
    logic               btn_level;
    logic [DEB_W-1:0]   stable_cnt;
    logic               press;
    logic [DWL_W-1:0]   dwell;
    logic [DWL_W-1:0]   dwell_next;
    logic [1:0]         sel_next;

    // Without valid statistics the rotation collapses to SET <-> AVE.
    function automatic logic [1:0] nxt_slot(input logic [1:0] s, input logic valid);
        logic [1:0] n;
        n = s + 2'd1;
        if (!valid && n[1]) begin
            n = 2'b00;
        end
        return n;
    endfunction

    // Stage p0/p1: two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            btn_sync_p0  <= 1'b0;
            btn_sync_p1  <= 1'b0;
            auto_sync_p0 <= 1'b0;
            auto_sync_p1 <= 1'b0;
        end else begin
            btn_sync_p0  <= btn_next;
            btn_sync_p1  <= btn_sync_p0;
            auto_sync_p0 <= auto_en;
            auto_sync_p1 <= auto_sync_p0;
        end
    end

    assign tick = (prescale == PRE_LAST);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // A new level must be seen on DEBOUNCE_MS consecutive ticks before it is accepted.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            btn_level  <= 1'b0;
            stable_cnt <= '0;
        end else if (tick) begin
            if (btn_sync_p1 != btn_level) begin
                if (stable_cnt == DEB_LAST) begin
                    btn_level  <= ~btn_level;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    // The press fires on the same tick as the 0->1 flip so it can coincide with dwell expiry.
    assign press = tick && btn_sync_p1 && !btn_level && (stable_cnt == DEB_LAST);

    always_comb begin
        state_next = state;
        sel_next   = sel;
        dwell_next = dwell;

        if (!stats_valid && sel[1]) begin
            sel_next   = 2'b00;
            dwell_next = '0;
        end else if (press) begin
            sel_next   = nxt_slot(sel, stats_valid);
            dwell_next = '0;
        end else if (state == AUTO && tick) begin
            if (dwell == DWL_LAST) begin
                sel_next   = nxt_slot(sel, stats_valid);
                dwell_next = '0;
            end else begin
                dwell_next = dwell + 1'b1;
            end
        end

        if (state == MANUAL) begin
            dwell_next = '0;
            if (auto_sync_p1) begin
                state_next = AUTO;
            end
        end else if (!auto_sync_p1) begin
            state_next = MANUAL;
        end
    end

    // Stage p2: mode, selector and dwell registers
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state      <= MANUAL;
            sel        <= 2'b00;
            sel_change <= 1'b0;
            dwell      <= '0;
        end else begin
            state      <= state_next;
            sel        <= sel_next;
            sel_change <= (sel_next != sel);
            dwell      <= dwell_next;
        end
    end

    assign auto_mode = (state == AUTO);

endmodule

// File: tb/tb_display_sequencer.sv
// Self-checking bench for display_sequencer: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model.
module tb_display_sequencer;

    localparam int TDIV = 4;
    localparam int DW   = 5;
    localparam int DB   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_next = 1'b0;
    logic       auto_en = 1'b0;
    logic       stats_valid = 1'b1;
    logic [1:0] sel;
    logic       sel_change;
    logic       auto_mode;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;

    display_sequencer #(
        .TICK_DIV    (TDIV),
        .DWELL_MS    (DW),
        .DEBOUNCE_MS (DB)
    ) dut (
        .CLK100MHZ   (clk),
        .reset       (reset),
        .btn_next    (btn_next),
        .auto_en     (auto_en),
        .stats_valid (stats_valid),
        .sel         (sel),
        .sel_change  (sel_change),
        .auto_mode   (auto_mode)
    );

    always #5 clk = ~clk;

    // Cycles since the last reset edge: after edge n, ncyc == n.
    always @(posedge clk) ncyc <= reset ? 0 : ncyc + 1;

    // Behavioural reference model.
    int       m_cyc = 0;
    int       m_stable = 0;
    int       m_dwell = 0;
    bit       m_level = 0;
    bit       m_auto = 0;
    bit [1:0] m_bh = '0;
    bit [1:0] m_ah = '0;
    bit [1:0] m_sel = '0;
    bit       m_chg = 0;

    function automatic bit [1:0] model_next(input bit [1:0] s, input bit v);
        int i;
        i = int'(s);
        if (v) return 2'((i + 1) % 4);
        return (s == 2'd0) ? 2'd1 : 2'd0;
    endfunction

    always @(posedge clk) begin : ref_model
        bit       tick;
        bit       sb;
        bit       sa;
        bit       press;
        bit [1:0] ns;
        int       nd;
        if (reset) begin
            m_cyc <= 0; m_stable <= 0; m_dwell <= 0; m_level <= 0; m_auto <= 0;
            m_bh <= '0; m_ah <= '0; m_sel <= '0; m_chg <= 0;
        end else begin
            tick  = (m_cyc % TDIV) == TDIV - 1;
            sb    = m_bh[1];
            sa    = m_ah[1];
            press = tick && sb && !m_level && (m_stable + 1 == DB);
            ns = m_sel;
            nd = m_dwell;
            if (!stats_valid && m_sel >= 2'd2) begin
                ns = 2'd0; nd = 0;
            end else if (press) begin
                ns = model_next(m_sel, stats_valid); nd = 0;
            end else if (m_auto && tick) begin
                nd = m_dwell + 1;
                if (nd == DW) begin
                    ns = model_next(m_sel, stats_valid); nd = 0;
                end
            end
            if (!m_auto) nd = 0;
            if (tick) begin
                if (sb != m_level) begin
                    if (m_stable + 1 == DB) begin
                        m_level <= sb; m_stable <= 0;
                    end else begin
                        m_stable <= m_stable + 1;
                    end
                end else begin
                    m_stable <= 0;
                end
            end
            m_sel   <= ns;
            m_dwell <= nd;
            m_chg   <= (ns != m_sel);
            m_auto  <= sa;
            m_bh    <= {m_bh[0], btn_next};
            m_ah    <= {m_ah[0], auto_en};
            m_cyc   <= m_cyc + 1;
        end
    end

    task automatic do_reset(input bit a);
        @(negedge clk);
        reset = 1'b1; btn_next = 1'b0; auto_en = 1'b0; stats_valid = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; auto_en = a;
    endtask

    task automatic goto(input int n);
        if (n > ncyc) repeat (n - ncyc) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sel !== 2'b00 || sel_change !== 1'b0 || auto_mode !== 1'b0) begin
            failures++;
            $display("FAIL reset_state sel=%b chg=%b auto=%b required 00/0/0", sel, sel_change, auto_mode);
        end
    endtask

    task automatic test_long_press();
        int pulses = 0;
        do_reset(1'b0);
        btn_next = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            goto(n);
            if (sel_change) pulses++;
            if (n == 11) begin
                checks++;
                if (sel !== 2'b00) begin
                    failures++; $display("FAIL press_early sel=%b required 00", sel);
                end
            end
            if (n == 12) begin
                checks++;
                if (sel !== 2'b01 || sel_change !== 1'b1) begin
                    failures++; $display("FAIL press_step sel=%b chg=%b required 01/1", sel, sel_change);
                end
            end
            if (n == 16) btn_next = 1'b0;
        end
        checks++;
        if (pulses != 1 || sel !== 2'b01) begin
            failures++; $display("FAIL press_release pulses=%0d sel=%b required 1/01", pulses, sel);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        do_reset(1'b0);
        btn_next = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            goto(n);
            if (sel_change) pulses++;
            if (n == 6) btn_next = 1'b0;
        end
        checks++;
        if (pulses != 0 || sel !== 2'b00) begin
            failures++; $display("FAIL glitch pulses=%0d sel=%b required 0/00", pulses, sel);
        end
    endtask

    task automatic test_auto_rotate();
        do_reset(1'b1);
        goto(3);
        checks++;
        if (auto_mode !== 1'b1) begin
            failures++; $display("FAIL auto_mode_on got=%b required 1", auto_mode);
        end
        for (int k = 1; k <= 4; k++) begin
            goto(20 * k - 1);
            checks++;
            if (sel !== 2'((k - 1) % 4)) begin
                failures++; $display("FAIL auto_hold k=%0d sel=%b required %0d", k, sel, (k - 1) % 4);
            end
            goto(20 * k);
            checks++;
            if (sel !== 2'(k % 4) || sel_change !== 1'b1) begin
                failures++; $display("FAIL auto_step k=%0d sel=%b chg=%b required %0d/1", k, sel, sel_change, k % 4);
            end
        end
    endtask

    task automatic test_stats_invalid();
        bit [1:0] exp_seq [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
        do_reset(1'b1);
        stats_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            goto(20 * k);
            checks++;
            if (sel !== exp_seq[k - 1]) begin
                failures++; $display("FAIL invalid_rotate k=%0d sel=%b required %b", k, sel, exp_seq[k - 1]);
            end
        end
        do_reset(1'b1);
        goto(60);
        checks++;
        if (sel !== 2'b11) begin
            failures++; $display("FAIL invalid_pre sel=%b required 11", sel);
        end
        stats_valid = 1'b0;
        goto(61);
        checks++;
        if (sel !== 2'b00 || sel_change !== 1'b1) begin
            failures++; $display("FAIL invalid_drop sel=%b chg=%b required 00/1", sel, sel_change);
        end
        goto(79);
        checks++;
        if (sel !== 2'b00) begin
            failures++; $display("FAIL invalid_dwell_hold sel=%b required 00", sel);
        end
        goto(80);
        checks++;
        if (sel !== 2'b01) begin
            failures++; $display("FAIL invalid_dwell_step sel=%b required 01", sel);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        goto(28);
        btn_next = 1'b1;
        goto(39);
        checks++;
        if (sel !== 2'b01) begin
            failures++; $display("FAIL coincide_pre sel=%b required 01", sel);
        end
        goto(40);
        checks++;
        if (sel !== 2'b10 || sel_change !== 1'b1) begin
            failures++; $display("FAIL coincide_step sel=%b chg=%b required 10/1", sel, sel_change);
        end
        goto(41);
        checks++;
        if (sel !== 2'b10 || sel_change !== 1'b0) begin
            failures++; $display("FAIL coincide_single sel=%b chg=%b required 10/0", sel, sel_change);
        end
        goto(44);
        btn_next = 1'b0;
        goto(59);
        checks++;
        if (sel !== 2'b10) begin
            failures++; $display("FAIL coincide_hold sel=%b required 10", sel);
        end
        goto(60);
        checks++;
        if (sel !== 2'b11) begin
            failures++; $display("FAIL coincide_next sel=%b required 11", sel);
        end
    endtask

    task automatic test_reset_mid_dwell();
        do_reset(1'b1);
        goto(40);
        checks++;
        if (sel !== 2'b10) begin
            failures++; $display("FAIL middwell_pre sel=%b required 10", sel);
        end
        goto(50);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (sel !== 2'b00 || auto_mode !== 1'b0 || sel_change !== 1'b0) begin
            failures++; $display("FAIL middwell_reset sel=%b auto=%b chg=%b required 00/0/0", sel, auto_mode, sel_change);
        end
        reset = 1'b0;
        goto(19);
        checks++;
        if (sel !== 2'b00) begin
            failures++; $display("FAIL middwell_hold sel=%b required 00", sel);
        end
        goto(20);
        checks++;
        if (sel !== 2'b01) begin
            failures++; $display("FAIL middwell_step sel=%b required 01", sel);
        end
    endtask

    task automatic test_random();
        int bt = 1;
        int at = 1;
        int st = 1;
        do_reset(1'b0);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            checks++;
            if (sel !== m_sel || sel_change !== m_chg || auto_mode !== m_auto) begin
                failures++;
                $display("FAIL random n=%0d sel=%b chg=%b auto=%b required %b/%b/%b",
                         n, sel, sel_change, auto_mode, m_sel, m_chg, m_auto);
            end
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 799) == 0) reset = 1'b1;
            if (--bt == 0) begin btn_next = ~btn_next; bt = $urandom_range(1, 40); end
            if (--at == 0) begin auto_en = ~auto_en; at = $urandom_range(20, 250); end
            if (--st == 0) begin stats_valid = ~stats_valid; st = $urandom_range(30, 300); end
        end
    endtask

    initial begin
        test_reset();
        test_long_press();
        test_glitch();
        test_auto_rotate();
        test_stats_invalid();
        test_back_to_back();
        test_reset_mid_dwell();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
